pe_mac_sequencer: RTL and testbench
===================================

// Module: pe_mac_sequencer
// PURPOSE
//  Initiator side of the PE in_valid/out_valid MAC handshake. Takes a dot-product job
//  (length K, initial psum), then pulls K FP32 operand pairs from a ready/valid stream.
//  Issues each pair to one pe as a 1-cycle in_valid pulse and chains psum_out back into
//  psum_in. Returns the final FP32 sum. Sits between the operand buffer and one pe.
// PARAMETERS
//  LEN_W       16    width of job length K (0..2^LEN_W-1)
//  TIMEOUT_CYC 4096  max cycles waiting for pe_out_valid before job aborts with error
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst_n        in   1      async active-low reset
//  cmd_valid    in   1      job request
//  cmd_ready    out  1      high only in IDLE
//  cmd_len      in   LEN_W  K, number of MAC terms
//  cmd_init     in   32     initial psum (FP32 bits)
//  op_valid     in   1      operand pair valid
//  op_ready     out  1      high only in FETCH/DRAIN
//  op_a, op_b   in   32     FP32 operand bits
//  pe_in_valid  out  1      1-cycle issue pulse to pe
//  pe_a_bits    out  32     operand a to pe
//  pe_b_bits    out  32     operand b to pe
//  pe_psum_in   out  32     running psum to pe
//  pe_out_valid in   1      pe completion pulse
//  pe_psum_out  in   32     pe result
//  res_valid    out  1      result available, held until res_ready
//  res_ready    in   1      result accepted
//  res_bits     out  32     final psum
//  res_err      out  1      job aborted by timeout (valid with res_valid)
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; pe_in_valid, res_valid, res_err = 0; all data regs = 0. Reset may
//  hit any state; afterwards a pending pe_out_valid is ignored (not in WAIT).
//  FSM: IDLE, FETCH, ISSUE, WAIT, DRAIN, DONE.
//  - IDLE: cmd_valid&cmd_ready -> acc=cmd_init, len=cmd_len, cnt=0, err=0.
//    len==0 -> DONE (res_bits=cmd_init, no pe issue). Else -> FETCH.
//  - FETCH: op_valid&op_ready -> latch a,b -> ISSUE.
//  - ISSUE: one cycle. Registered pe_in_valid=1 in the following cycle only.
//    pe_a/b/psum_in = latched a, b, acc; held stable until WAIT exits. Clear watchdog. -> WAIT.
//  - WAIT: pe_out_valid -> acc=pe_psum_out, cnt++; cnt+1==len -> DONE, else FETCH.
//    Watchdog reaches TIMEOUT_CYC without pe_out_valid -> err=1; -> DRAIN, or -> DONE if
//    cnt+1==len. pe_out_valid and timeout in same cycle: pe_out_valid wins.
//  - DRAIN: accept and discard remaining len-cnt-1 pairs (op_ready=1, no pe issue), then DONE.
//    Keeps the operand stream aligned to job boundaries.
//  - DONE: res_valid=1, res_bits=acc, res_err=err, held stable. res_ready -> IDLE.
//    The next cmd can be accepted no earlier than the cycle after the result handshake.
//  pe_out_valid outside WAIT is ignored. Exactly one issue outstanding at a time.
//  cnt and len are LEN_W bits; K=2^LEN_W-1 has no wrap (compare uses cnt+1 at LEN_W+1 bits).
//  Minimum cost per term: 1 (FETCH) + 1 (ISSUE) + pe latency cycles.
// STRUCTURE
//  pe_seq_pkg: state enum seq_state_t; FP32_ZERO=32'h0000_0000; FP32_W=32.
//  Sub-module pe_seq_watchdog: counter with clear/enable/expired, parameter TIMEOUT_CYC.
//  No FP arithmetic inside this block; all math is done in pe.
// TESTING (bench: this block + real pe, or a stub pe with programmable latency)
//  1 K=3, init=0, pairs (40000000,40400000),(3F800000,3F800000),(BFC00000,40800000)
//    -> 3 pe_in_valid pulses, res_bits=3F800000, res_err=0.
//  2 K=0, init=41200000 -> res_valid 2 cycles after cmd handshake, res_bits=41200000,
//    pe_in_valid never asserted, op_ready never high.
//  3 Stub pe never responds, TIMEOUT_CYC=16, K=3 -> res_err=1 at most 16 cycles after
//    first issue; remaining 2 pairs consumed with no pe_in_valid; next job (test 1) passes.
//  4 res_ready low 5 cycles in DONE -> res_valid/res_bits/res_err stable, cmd_ready=0;
//    handshake -> IDLE.
//  5 rst_n low during WAIT, pe_out_valid arrives 2 cycles after release -> outputs at reset
//    values, state IDLE, pulse ignored, busy=0.
//  6 Stray pe_out_valid in FETCH plus op_valid gaps (random 0-3 cycles)
//    -> result still matches test 1; exactly one in_valid per pair.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE MAC sequencer.
package pe_seq_pkg;

   localparam int          FP32_W    = 32;
   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// Command, operand-stream, pe and result handshakes of the MAC sequencer.
interface pe_mac_sequencer_if #(
   parameter int LEN_W = 16
);
   import pe_seq_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [LEN_W-1:0]  cmd_len;
   logic [FP32_W-1:0] cmd_init;

   logic              op_valid;
   logic              op_ready;
   logic [FP32_W-1:0] op_a;
   logic [FP32_W-1:0] op_b;

   logic              pe_in_valid;
   logic [FP32_W-1:0] pe_a_bits;
   logic [FP32_W-1:0] pe_b_bits;
   logic [FP32_W-1:0] pe_psum_in;
   logic              pe_out_valid;
   logic [FP32_W-1:0] pe_psum_out;

   logic              res_valid;
   logic              res_ready;
   logic [FP32_W-1:0] res_bits;
   logic              res_err;

   logic              busy;

   // master is the sequencer itself
   modport master (
      input  cmd_valid, cmd_len, cmd_init,
      output cmd_ready,
      input  op_valid, op_a, op_b,
      output op_ready,
      output pe_in_valid, pe_a_bits, pe_b_bits, pe_psum_in,
      input  pe_out_valid, pe_psum_out,
      output res_valid, res_bits, res_err,
      input  res_ready,
      output busy
   );

   modport slave (
      output cmd_valid, cmd_len, cmd_init,
      input  cmd_ready,
      output op_valid, op_a, op_b,
      input  op_ready,
      input  pe_in_valid, pe_a_bits, pe_b_bits, pe_psum_in,
      output pe_out_valid, pe_psum_out,
      input  res_valid, res_bits, res_err,
      output res_ready,
      input  busy
   );

endinterface

// File: rtl/pe_seq_watchdog.sv
// Cycle counter bounding how long the sequencer waits for a pe completion.
module pe_seq_watchdog #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_reg;

   // Fires on the TIMEOUT_CYC-th enabled cycle after a clear
   assign expired = enable && (count_reg == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Sequences one dot-product job through a single pe, chaining psum_out back into psum_in.
module pe_mac_sequencer
   import pe_seq_pkg::*;
#(
   parameter int LEN_W       = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic                clk,
   input logic                rst_n,
   pe_mac_sequencer_if.master seq
);

   seq_state_t        state_reg, state_next;
   logic [FP32_W-1:0] acc_reg, acc_next;
   logic [FP32_W-1:0] a_reg, a_next;
   logic [FP32_W-1:0] b_reg, b_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic [LEN_W-1:0]  cnt_reg, cnt_next;
   logic              err_reg, err_next;
   logic              in_valid_reg;
   logic              res_valid_reg;

   logic              wd_clear;
   logic              wd_enable;
   logic              wd_expired;
   logic [LEN_W:0]    cnt_inc;
   logic              last_term;
   logic              res_hs;

   // One extra bit so K = 2^LEN_W-1 completes without wrapping
   assign cnt_inc   = {1'b0, cnt_reg} + 1'b1;
   assign last_term = (cnt_inc == {1'b0, len_reg});
   assign res_hs    = res_valid_reg && seq.res_ready;

   pe_seq_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      len_next   = len_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      wd_clear   = 1'b0;
      wd_enable  = 1'b0;
      unique case (state_reg)
         S_IDLE: begin
            if (seq.cmd_valid) begin
               acc_next   = seq.cmd_init;
               len_next   = seq.cmd_len;
               cnt_next   = '0;
               err_next   = 1'b0;
               state_next = (seq.cmd_len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (seq.op_valid) begin
               a_next     = seq.op_a;
               b_next     = seq.op_b;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wd_clear   = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            wd_enable = 1'b1;
            // A completion in the same cycle as the timeout takes priority
            if (seq.pe_out_valid) begin
               acc_next   = seq.pe_psum_out;
               cnt_next   = cnt_inc[LEN_W-1:0];
               state_next = last_term ? S_DONE : S_FETCH;
            end else if (wd_expired) begin
               err_next   = 1'b1;
               cnt_next   = cnt_inc[LEN_W-1:0];
               state_next = last_term ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Swallow the aborted job's remaining pairs to stay aligned to job boundaries
            if (seq.op_valid) begin
               cnt_next = cnt_inc[LEN_W-1:0];
               if (last_term) begin
                  state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (res_hs) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         acc_reg       <= FP32_ZERO;
         a_reg         <= FP32_ZERO;
         b_reg         <= FP32_ZERO;
         len_reg       <= '0;
         cnt_reg       <= '0;
         err_reg       <= 1'b0;
         in_valid_reg  <= 1'b0;
         res_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         len_reg       <= len_next;
         cnt_reg       <= cnt_next;
         err_reg       <= err_next;
         in_valid_reg  <= (state_reg == S_ISSUE);
         res_valid_reg <= (state_reg == S_DONE) && !res_hs;
      end
   end

   assign seq.cmd_ready   = (state_reg == S_IDLE);
   assign seq.op_ready    = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
   assign seq.pe_in_valid = in_valid_reg;
   assign seq.pe_a_bits   = a_reg;
   assign seq.pe_b_bits   = b_reg;
   assign seq.pe_psum_in  = acc_reg;
   assign seq.res_valid   = res_valid_reg;
   assign seq.res_bits    = acc_reg;
   assign seq.res_err     = err_reg;
   assign seq.busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Scoreboard bench for pe_mac_sequencer driving a latency-programmable stub pe.
module tb_pe_mac_sequencer;

   typedef struct {
      logic [31:0] bits;
      logic        err;
      int          issues;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pe_mac_sequencer_if #(.LEN_W(16)) sif ();

   pe_mac_sequencer #(
      .LEN_W       (16),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq   (sif)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   logic [31:0] t_a [3];
   logic [31:0] t_b [3];

   // stub pe state
   logic        stub_valid  = 1'b0;
   logic [31:0] stub_psum   = 32'h0;
   int          stub_cnt    = 0;
   int          pe_lat      = 1;
   bit          pe_mute     = 1'b0;
   logic        stray_valid = 1'b0;

   // monitor state
   int   cyc            = 0;
   int   job_issues     = 0;
   int   op_ready_cnt   = 0;
   int   last_issue_cyc = 0;
   int   err_rise_cyc   = 0;
   logic err_prev       = 1'b0;
   int   n_res          = 0;

   assign sif.pe_out_valid = stub_valid | stray_valid;
   assign sif.pe_psum_out  = stray_valid ? 32'hDEAD_BEEF : stub_psum;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) repeat (e) r = r * 2.0;
      else repeat (-e) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp2r(input logic [31:0] x);
      real v;
      if (x[30:0] == 31'h0) return 0.0;
      v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
      return x[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2fp(input real v);
      logic        s;
      int          e = 0;
      real         m;
      int unsigned frac;
      if (v == 0.0) return 32'h0;
      s = (v < 0.0);
      m = s ? -v : v;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      frac = $rtoi((m - 1.0) * 8388608.0 + 0.5);
      if (frac >= 8388608) begin frac = 0; e++; end
      return {s, 8'(e + 127), frac[22:0]};
   endfunction

   // Stub pe: psum_out = psum_in + a*b after pe_lat cycles, unless muted
   always @(posedge clk) begin
      stub_valid <= 1'b0;
      if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) stub_valid <= 1'b1;
      end else if (sif.pe_in_valid && !pe_mute) begin
         stub_psum <= r2fp(fp2r(sif.pe_psum_in) + fp2r(sif.pe_a_bits) * fp2r(sif.pe_b_bits));
         if (pe_lat <= 1) stub_valid <= 1'b1;
         else stub_cnt <= pe_lat - 1;
      end
   end

   // Monitor and scoreboard collector, sampled mid-cycle
   always @(negedge clk) begin
      cyc      <= cyc + 1;
      err_prev <= sif.res_err;
      if (sif.res_err && !err_prev) err_rise_cyc <= cyc;
      if (sif.pe_in_valid) last_issue_cyc <= cyc;
      if (sif.op_ready) op_ready_cnt <= op_ready_cnt + 1;
      if (sif.cmd_valid && sif.cmd_ready) job_issues <= 0;
      else if (sif.pe_in_valid) job_issues <= job_issues + 1;
      if (rst_n && sif.res_valid && sif.res_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            $display("res %0d: bits=%h err=%0d issues=%0d (exp %h/%0d/%0d)", n_res,
                     sif.res_bits, sif.res_err, job_issues, sb[0].bits, sb[0].err, sb[0].issues);
            chk("res_bits", sif.res_bits, sb[0].bits);
            chk("res_err", 32'(sif.res_err), 32'(sb[0].err));
            chk("issue_count", job_issues, sb[0].issues);
            void'(sb.pop_front());
         end
         n_res <= n_res + 1;
      end
   end

   task automatic send_cmd(input logic [15:0] len, input logic [31:0] init);
      bit ok = 1'b0;
      sif.cmd_valid = 1'b1;
      sif.cmd_len   = len;
      sif.cmd_init  = init;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sif.cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("cmd_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      sif.cmd_valid = 1'b0;
   endtask

   task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int gap, input bit stray);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sif.op_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("op_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (stray) begin
         stray_valid = 1'b1;
         @(posedge clk); #1;
         stray_valid = 1'b0;
      end
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      sif.op_valid = 1'b1;
      sif.op_a     = a;
      sif.op_b     = b;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sif.op_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("op_hs_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      sif.op_valid = 1'b0;
   endtask

   task automatic run_job(input logic [15:0] len, input logic [31:0] init, input int gap_max,
                          input bit stray, input logic [31:0] exp_bits, input logic exp_err,
                          input int exp_issues);
      sb.push_back('{bits: exp_bits, err: exp_err, issues: exp_issues});
      send_cmd(len, init);
      for (int i = 0; i < int'(len); i++) begin
         send_op(t_a[i], t_b[i], (gap_max == 0) ? 0 : int'($urandom_range(gap_max)), stray);
      end
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      chk(tag, sb.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int lat;
      int oc0;
      bit ok;
      t_a[0] = 32'h4000_0000; t_b[0] = 32'h4040_0000;
      t_a[1] = 32'h3F80_0000; t_b[1] = 32'h3F80_0000;
      t_a[2] = 32'hBFC0_0000; t_b[2] = 32'h4080_0000;
      sif.cmd_valid = 1'b0; sif.cmd_len = '0; sif.cmd_init = '0;
      sif.op_valid  = 1'b0; sif.op_a = '0; sif.op_b = '0;
      sif.res_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(sif.busy), 32'd0);
      chk("rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
      chk("rst_op_ready", 32'(sif.op_ready), 32'd0);
      chk("rst_pe_in_valid", 32'(sif.pe_in_valid), 32'd0);
      chk("rst_res_valid", 32'(sif.res_valid), 32'd0);
      chk("rst_res_err", 32'(sif.res_err), 32'd0);
      chk("rst_res_bits", sif.res_bits, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic 3-term job
      run_job(16'd3, 32'h0, 0, 1'b0, 32'h3F80_0000, 1'b0, 3);
      wait_empty("t1_done");

      // K = 0: result straight from init, no pe traffic
      oc0 = op_ready_cnt;
      sb.push_back('{bits: 32'h4120_0000, err: 1'b0, issues: 0});
      send_cmd(16'd0, 32'h4120_0000);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (sif.res_valid) begin lat = i; break; end
      end
      chk("t2_res_latency", lat, 32'd2);
      wait_empty("t2_done");
      chk("t2_op_ready_never", op_ready_cnt - oc0, 32'd0);

      // pe never answers: timeout, drain, then a normal job
      pe_mute = 1'b1;
      run_job(16'd3, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1);
      wait_empty("t3_done");
      chk("t3_err_within_16", ((err_rise_cyc - last_issue_cyc) >= 1 &&
                               (err_rise_cyc - last_issue_cyc) <= 16) ? 32'd1 : 32'd0, 32'd1);
      pe_mute = 1'b0;
      run_job(16'd3, 32'h0, 0, 1'b0, 32'h3F80_0000, 1'b0, 3);
      wait_empty("t3_next_done");

      // result back-pressure
      sif.res_ready = 1'b0;
      run_job(16'd3, 32'h0, 0, 1'b0, 32'h3F80_0000, 1'b0, 3);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sif.res_valid) begin ok = 1'b1; break; end
      end
      chk("t4_res_valid_seen", 32'(ok), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("t4_hold_valid", 32'(sif.res_valid), 32'd1);
         chk("t4_hold_bits", sif.res_bits, 32'h3F80_0000);
         chk("t4_hold_err", 32'(sif.res_err), 32'd0);
         chk("t4_hold_cmd_ready", 32'(sif.cmd_ready), 32'd0);
      end
      @(posedge clk); #1;
      sif.res_ready = 1'b1;
      wait_empty("t4_done");
      @(negedge clk);
      chk("t4_idle_busy", 32'(sif.busy), 32'd0);
      chk("t4_idle_cmd_ready", 32'(sif.cmd_ready), 32'd1);
      @(posedge clk); #1;

      // reset in WAIT, late pe pulse must be ignored
      pe_mute = 1'b1;
      send_cmd(16'd3, 32'h4000_0000);
      send_op(t_a[0], t_b[0], 0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sif.pe_in_valid) begin ok = 1'b1; break; end
      end
      chk("t5_issue_seen", 32'(ok), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_in_rst_busy", 32'(sif.busy), 32'd0);
      chk("t5_in_rst_psum_in", sif.pe_psum_in, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      stray_valid = 1'b1;
      @(posedge clk); #1;
      stray_valid = 1'b0;
      @(negedge clk);
      chk("t5_busy", 32'(sif.busy), 32'd0);
      chk("t5_cmd_ready", 32'(sif.cmd_ready), 32'd1);
      chk("t5_op_ready", 32'(sif.op_ready), 32'd0);
      chk("t5_pe_in_valid", 32'(sif.pe_in_valid), 32'd0);
      chk("t5_res_valid", 32'(sif.res_valid), 32'd0);
      chk("t5_res_err", 32'(sif.res_err), 32'd0);
      chk("t5_res_bits", sif.res_bits, 32'h0);
      chk("t5_pe_a_bits", sif.pe_a_bits, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t5_still_idle", 32'(sif.busy), 32'd0);
      @(posedge clk); #1;
      pe_mute = 1'b0;

      // stray completions in FETCH, operand gaps, slower pe
      pe_lat = 3;
      run_job(16'd3, 32'h0, 3, 1'b1, 32'h3F80_0000, 1'b0, 3);
      wait_empty("t6_done");
      run_job(16'd3, 32'h0, 3, 1'b1, 32'h3F80_0000, 1'b0, 3);
      wait_empty("t6b_done");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
